// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port data memory arbiter:
// owner encoding, port ids, default latency/lock limits and the read tag.
package mem_port_arbiter_pkg;

    // Ownership FSM encoding
    localparam logic [1:0] ST_FREE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    // Requester ids (port 0 = accumulator controller, port 1 = host/loader)
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int DEF_READ_LAT = 2;
    localparam int DEF_MAX_LOCK = 16;

    // One in-flight read: valid bit plus the port that issued it
    typedef struct packed {
        logic vld;
        logic port;
    } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// Read tag delay line: follows each registered memory read for READ_LAT
// cycles so the returning MemRData can be steered to the issuing port.
module rd_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int READ_LAT = DEF_READ_LAT
) (
    input  logic Clock,
    input  logic Reset,
    input  logic in_vld,
    input  logic in_port,
    output logic RValid0,
    output logic RValid1
);

    rd_tag_t [READ_LAT-1:0] tag_pipe;

    // Shift tags one stage per cycle; reset drops everything in flight
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0] <= rd_tag_t'({in_vld, in_port});
            for (int i = 1; i < READ_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign RValid0 = tag_pipe[READ_LAT-1].vld && (tag_pipe[READ_LAT-1].port == PORT0);
    assign RValid1 = tag_pipe[READ_LAT-1].vld && (tag_pipe[READ_LAT-1].port == PORT1);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port data memory. Round-robin per
// cycle, with a Lock mode that keeps ownership across idle cycles and a
// timeout that releases a lock once the other port has waited MAX_LOCK cycles.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 16,
    parameter int READ_LAT = DEF_READ_LAT,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              We0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [DATA_W-1:0] WData0,
    input  logic              Lock0,
    input  logic              Req1,
    input  logic              We1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData1,
    input  logic              Lock1,
    output logic              Gnt0,
    output logic              Gnt1,
    output logic              RValid0,
    output logic              RValid1,
    output logic [DATA_W-1:0] RData,
    output logic              MemRe,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    logic [1:0]       own_q, own_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmd_port_q;

    // Grant decode: owner-only when locked, pointer breaks ties when free.
    // Held low during reset so no grant is reported while state is cleared.
    always_comb begin
        Gnt0 = 1'b0;
        Gnt1 = 1'b0;
        if (!Reset) begin
            case (own_q)
                ST_FREE: begin
                    if (Req0 && Req1) begin
                        Gnt0 = (ptr_q == PORT0);
                        Gnt1 = (ptr_q == PORT1);
                    end else begin
                        Gnt0 = Req0;
                        Gnt1 = Req1;
                    end
                end
                ST_OWN0: Gnt0 = Req0;
                ST_OWN1: Gnt1 = Req1;
                default: ;
            endcase
        end
    end

    // Ownership, pointer and lock-timeout next state
    always_comb begin
        own_d = own_q;
        ptr_d = ptr_q;
        cnt_d = '0;
        case (own_q)
            ST_FREE: begin
                if (Gnt0) begin
                    ptr_d = PORT1;
                    if (Lock0) own_d = ST_OWN0;
                end else if (Gnt1) begin
                    ptr_d = PORT0;
                    if (Lock1) own_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!Lock0) begin
                    own_d = ST_FREE;
                    ptr_d = PORT1;
                end else if (Req1) begin
                    // Port 1 has waited its limit: hand the next contention to it
                    if (cnt_q == CNT_W'(MAX_LOCK - 1)) begin
                        own_d = ST_FREE;
                        ptr_d = PORT1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_OWN1: begin
                if (!Lock1) begin
                    own_d = ST_FREE;
                    ptr_d = PORT0;
                end else if (Req0) begin
                    if (cnt_q == CNT_W'(MAX_LOCK - 1)) begin
                        own_d = ST_FREE;
                        ptr_d = PORT0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: own_d = ST_FREE;
        endcase
    end

    // Arbitration state registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            own_q <= ST_FREE;
            ptr_q <= PORT0;
            cnt_q <= '0;
        end else begin
            own_q <= own_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Register the accepted command onto the memory interface
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            MemRe      <= 1'b0;
            MemWe      <= 1'b0;
            MemAddr    <= '0;
            MemWData   <= '0;
            cmd_port_q <= PORT0;
        end else begin
            MemRe <= (Gnt0 && !We0) || (Gnt1 && !We1);
            MemWe <= (Gnt0 &&  We0) || (Gnt1 &&  We1);
            if (Gnt0) begin
                MemAddr    <= Addr0;
                MemWData   <= WData0;
                cmd_port_q <= PORT0;
            end else if (Gnt1) begin
                MemAddr    <= Addr1;
                MemWData   <= WData1;
                cmd_port_q <= PORT1;
            end
        end
    end

    // Tags start at the registered read so they line up with MemRData
    rd_tag_pipe #(
        .READ_LAT(READ_LAT)
    ) u_rd_tag_pipe (
        .Clock  (Clock),
        .Reset  (Reset),
        .in_vld (MemRe),
        .in_port(cmd_port_q),
        .RValid0(RValid0),
        .RValid1(RValid1)
    );

    assign RData = MemRData;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Reads push the expected
// {port, data} into a scoreboard; a monitor pops on every RValid.
// A second instance with MAX_LOCK=4 shares the stimulus for the timeout case.
module tb_mem_port_arbiter;

    localparam int AW = 6;
    localparam int DW = 16;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          Req0, We0, Lock0, Req1, We1, Lock1;
    logic [AW-1:0] Addr0, Addr1;
    logic [DW-1:0] WData0, WData1;
    logic [DW-1:0] MemRData;

    logic          Gnt0, Gnt1, RValid0, RValid1, MemRe, MemWe;
    logic [DW-1:0] RData, MemWData;
    logic [AW-1:0] MemAddr;

    logic          Gnt0_l, Gnt1_l, RValid0_l, RValid1_l, MemRe_l, MemWe_l;
    logic [DW-1:0] RData_l, MemWData_l;
    logic [AW-1:0] MemAddr_l;

    int   total = 0;
    int   bad   = 0;
    exp_t sbq[$];

    logic [DW-1:0] mem [64];
    logic [DW-1:0] rd_pipe [2];

    always #5 Clock = ~Clock;

    mem_port_arbiter dut (
        .Clock(Clock), .Reset(Reset),
        .Req0(Req0), .We0(We0), .Addr0(Addr0), .WData0(WData0), .Lock0(Lock0),
        .Req1(Req1), .We1(We1), .Addr1(Addr1), .WData1(WData1), .Lock1(Lock1),
        .Gnt0(Gnt0), .Gnt1(Gnt1), .RValid0(RValid0), .RValid1(RValid1), .RData(RData),
        .MemRe(MemRe), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemRData(MemRData)
    );

    mem_port_arbiter #(.MAX_LOCK(4)) dut_l (
        .Clock(Clock), .Reset(Reset),
        .Req0(Req0), .We0(We0), .Addr0(Addr0), .WData0(WData0), .Lock0(Lock0),
        .Req1(Req1), .We1(We1), .Addr1(Addr1), .WData1(WData1), .Lock1(Lock1),
        .Gnt0(Gnt0_l), .Gnt1(Gnt1_l), .RValid0(RValid0_l), .RValid1(RValid1_l), .RData(RData_l),
        .MemRe(MemRe_l), .MemWe(MemWe_l), .MemAddr(MemAddr_l), .MemWData(MemWData_l),
        .MemRData(MemRData)
    );

    // Memory model, latency 2 from the registered command
    assign MemRData = rd_pipe[1];
    always @(posedge Clock) begin
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[0] <= mem[MemAddr];
        if (MemWe) mem[MemAddr] = MemWData;
    end

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'(16'hA000 + a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Read-return monitor
    always @(posedge Clock) begin
        exp_t e;
        #3;
        if (RValid0 || RValid1) begin
            chk("rv_both", 32'(RValid0 & RValid1), 0);
            if (sbq.size() == 0) begin
                chk("rv_unexp", {30'd0, RValid1, RValid0}, 0);
            end else begin
                e = sbq.pop_front();
                chk("rv_port", 32'(RValid1), 32'(e.port));
                chk("rv_data", 32'(RData), 32'(e.data));
            end
        end
    end

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic set_in(input logic r0, input logic w0, input int a0, input logic [DW-1:0] d0,
                          input logic l0, input logic r1, input logic w1, input int a1,
                          input logic [DW-1:0] d1, input logic l1);
        Req0 = r0; We0 = w0; Addr0 = AW'(a0); WData0 = d0; Lock0 = l0;
        Req1 = r1; We1 = w1; Addr1 = AW'(a1); WData1 = d1; Lock1 = l1;
    endtask

    task automatic idle;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic p, input logic [DW-1:0] d);
        exp_t e;
        e.port = p;
        e.data = d;
        sbq.push_back(e);
    endtask

    task automatic chk_rst_vals(input string tag);
        chk({tag, "_gnt"},   {30'd0, Gnt1, Gnt0}, 0);
        chk({tag, "_strb"},  {30'd0, MemWe, MemRe}, 0);
        chk({tag, "_addr"},  32'(MemAddr), 0);
        chk({tag, "_wdata"}, 32'(MemWData), 0);
        chk({tag, "_rv"},    {30'd0, RValid1, RValid0}, 0);
    endtask

    task automatic do_reset;
        Reset = 1'b1;
        idle();
        tick();
        tick();
        Reset = 1'b0;
        sbq.delete();
    endtask

    task automatic drain(input string tag);
        idle();
        repeat (7) tick();
        chk(tag, sbq.size(), 0);
        sbq.delete();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = init_val(i);
        rd_pipe[0] = '0;
        rd_pipe[1] = '0;

        // Reset values, with both ports requesting during reset
        set_in(1, 0, 3, 0, 1, 1, 0, 4, 0, 1);
        #2;
        chk_rst_vals("rst0");
        tick();
        tick();
        chk_rst_vals("rst1");
        do_reset();

        // Port 0 alone, consecutive reads at 5, 6, 7
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                chk("t1_re", 32'(MemRe), 1);
                chk("t1_addr", 32'(MemAddr), 32'(5 + k - 1));
            end
            set_in(1, 0, 5 + k, 0, 0, 0, 0, 0, 0, 0);
            #1;
            chk("t1_gnt", {30'd0, Gnt1, Gnt0}, 32'b01);
            push(0, init_val(5 + k));
            tick();
        end
        chk("t1_addr", 32'(MemAddr), 7);
        drain("t1_sb");

        // Both ports read every cycle: alternating grants from port 0
        do_reset();
        for (int k = 0; k < 6; k++) begin
            set_in(1, 0, 16 + k, 0, 0, 1, 0, 32 + k, 0, 0);
            #1;
            chk("t2_gnt", {30'd0, Gnt1, Gnt0}, (k % 2 == 0) ? 32'b01 : 32'b10);
            if (k % 2 == 0) push(0, init_val(16 + k));
            else            push(1, init_val(32 + k));
            tick();
        end
        drain("t2_sb");

        // Lock0 for 6 cycles, Req0 only at 0 and 4, Req1 throughout
        do_reset();
        for (int c = 0; c < 8; c++) begin
            set_in((c == 0 || c == 4), 0, 3, 0, (c < 6), 1, 0, 9, 0, 0);
            #1;
            chk("t3_gnt0", 32'(Gnt0), 32'(c == 0 || c == 4));
            chk("t3_gnt1", 32'(Gnt1), 32'(c == 7));
            if (c == 0 || c == 4) push(0, init_val(3));
            if (c == 7) push(1, init_val(9));
            tick();
        end
        drain("t3_sb");

        // Lock timeout: MAX_LOCK=4 instance releases, default one does not
        do_reset();
        for (int c = 0; c < 8; c++) begin
            set_in((c == 0 || c == 6), 0, 1, 0, 1, 1, 0, 2, 0, 0);
            #1;
            chk("t4_l_gnt0", 32'(Gnt0_l), 32'(c == 0 || c == 6));
            chk("t4_l_gnt1", 32'(Gnt1_l), 32'(c == 5));
            chk("t4_gnt0", 32'(Gnt0), 32'(c == 0 || c == 6));
            chk("t4_gnt1", 32'(Gnt1), 0);
            if (c == 0 || c == 6) push(0, init_val(1));
            tick();
        end
        drain("t4_sb");

        // Port 1 writes BEEF to 10, then port 0 reads it back
        do_reset();
        set_in(0, 0, 0, 0, 0, 1, 1, 10, 16'hBEEF, 0);
        #1;
        chk("t5_gnt_w", {30'd0, Gnt1, Gnt0}, 32'b10);
        tick();
        chk("t5_we", {30'd0, MemWe, MemRe}, 32'b10);
        chk("t5_waddr", 32'(MemAddr), 10);
        chk("t5_wdata", 32'(MemWData), 32'hBEEF);
        set_in(1, 0, 10, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t5_gnt_r", {30'd0, Gnt1, Gnt0}, 32'b01);
        push(0, 16'hBEEF);
        tick();
        chk("t5_re", {30'd0, MemWe, MemRe}, 32'b01);
        chk("t5_raddr", 32'(MemAddr), 10);
        drain("t5_sb");

        // Reset one cycle after a granted read
        do_reset();
        set_in(1, 0, 7, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t6_gnt", {30'd0, Gnt1, Gnt0}, 32'b01);
        tick();
        chk("t6_re", 32'(MemRe), 1);
        Reset = 1'b1;
        set_in(1, 0, 7, 0, 0, 1, 0, 8, 0, 0);
        #1;
        chk_rst_vals("t6_rst");
        tick();
        tick();
        Reset = 1'b0;
        idle();
        repeat (6) tick();
        chk_rst_vals("t6_post");
        set_in(1, 0, 12, 0, 0, 1, 0, 13, 0, 0);
        #1;
        chk("t6_first", {30'd0, Gnt1, Gnt0}, 32'b01);
        push(0, init_val(12));
        tick();
        drain("t6_sb");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port data memory (read latency READ_LAT) between two requesters: port 0 is the accumulator controller, port 1 is the host/loader that fills and drains the memory.
- Round-robin arbitration per cycle, plus a Lock ownership mode so a requester can keep the memory across its idle cycles, for example between read-request and write-back.
- Returns a tagged read-valid to whichever port issued each read. A lock timeout bounds starvation.

Parameters:
- ADDR_W, 6, memory address width.
- DATA_W, 16, memory data width.
- READ_LAT, 2, cycles from a registered memory command to valid MemRData (≥1).
- MAX_LOCK, 16, maximum consecutive locked cycles while the other port is waiting.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Req0/Req1  in  1  transaction request.
- We0/We1  in  1  1 = write, 0 = read; sampled with Req.
- Addr0/Addr1  in  ADDR_W  address.
- WData0/WData1  in  DATA_W  write data.
- Lock0/Lock1  in  1  hold ownership while high.
- Gnt0/Gnt1  out  1  request accepted this cycle (combinational).
- RValid0/RValid1  out  1  RData valid for this port.
- RData  out  DATA_W  read data, shared; qualified by RValid0/RValid1.
- MemRe, MemWe  out  1  registered memory strobes.
- MemAddr  out  ADDR_W  registered memory address.
- MemWData  out  DATA_W  registered memory write data.
- MemRData  in  DATA_W  memory read data.

Behaviour:
- Reset values: Gnt0/1=0, MemRe=0, MemWe=0, MemAddr=0, MemWData=0, RValid0/1=0. Owner=FREE, priority pointer=port 0, lock counter=0, read-tag pipeline cleared.
- Ownership FSM states: FREE, OWN0, OWN1.
- FREE:
  - Only one port requesting → that port is granted.
  - Both ports requesting → the pointer port is granted.
  - After each grant in FREE, the pointer moves to the other port.
  - A granted port with Lock high → next state OWNx.
- OWNx:
  - Only port x can be granted. It is granted whenever Reqx=1.
  - The other port gets Gnt=0 even if it is requesting.
  - Ownership persists across cycles with Reqx=0 while Lockx=1.
  - Lockx=0 → FREE next cycle, with the pointer set to the other port.
- Lock timeout:
  - The counter increments each OWNx cycle in which the other port requests; otherwise it resets to 0.
  - Counter reaches MAX_LOCK → forced FREE, pointer set to the other port, counter cleared.
  - The other port then wins the next contended cycle.
  - Port x regains ownership later through normal arbitration if its Lock is still high.
- Accepted transaction (Req&Gnt at cycle t):
  - MemRe/MemWe, MemAddr and MemWData present it at cycle t+1.
  - Strobes are low in cycles with no grant.
- Reads:
  - Issuing port id and a valid bit enter a READ_LAT-deep tag shift register.
  - RValidx=1 at cycle t+1+READ_LAT, with RData=MemRData that cycle.
  - Back-to-back reads from either port give back-to-back RValid, in issue order.
- Writes produce no RValid.
- Gnt0 and Gnt1 are never both 1. At most one memory command per cycle.
- Lock without Req in FREE: ignored, no ownership is taken.
- Reset mid-operation: in-flight read tags are discarded and no RValid is asserted after reset releases. Ownership goes to FREE.
- Gnt depends only on current Req/Lock inputs and registered state. There is no combinational path from MemRData.

Decomposition:
- Shared package holds: owner state encoding (FREE=2'd0, OWN0=2'd1, OWN1=2'd2), port id constants, and the READ_LAT/MAX_LOCK defaults.
- One sub-module: rd_tag_pipe, a READ_LAT-deep shift register of {valid, port}. It produces RValid0/RValid1.

Test Plan:
- Port 0 alone, reads at Addr 5, 6, 7 in consecutive cycles → Gnt0=1 each cycle; MemAddr 5, 6, 7 at t+1..t+3; RValid0 at t+3..t+5 with matching data; RValid1 stays 0.
- Both ports request reads every cycle, no Lock → grants alternate 0, 1, 0, 1 starting with port 0 after reset; RValid sequence follows the same order READ_LAT+1 cycles later.
- Port 0 holds Lock0 for 6 cycles with Req0 only in cycles 0 and 4, Req1 constant → Gnt1=0 for all 6 cycles; Gnt1=1 in the cycle after Lock0 falls.
- MAX_LOCK=4, Lock0 held high indefinitely, Req1 constant → Gnt1=1 exactly after 4 waiting cycles; port 0 re-owns afterwards via arbitration.
- Port 1 writes 0xBEEF to Addr 10, then port 0 reads Addr 10 → MemWe=1 with MemWData=0xBEEF; RValid0=1 with RData=0xBEEF.
- Reset asserted one cycle after a granted read → no RValid after release; all outputs at reset values; the first post-reset contended grant goes to port 0.
